// File: rtl/toy_pack.sv
// Shared types and constants for the toy front-end blocks.
// Contents:
//   FETCH_DATA_WIDTH        width of one fetched line chunk returned to the ROB
//   ROB_ENTRY_ID_WIDTH      width of a ROB entry id
//   ICACHE_SLOT_NUM         default depth of the icache outstanding-request table
//   toy_icache_slot_state_e lifecycle of one outstanding-request slot
package toy_pack;

  localparam int FETCH_DATA_WIDTH   = 32;
  localparam int ROB_ENTRY_ID_WIDTH = 4;
  localparam int ICACHE_SLOT_NUM    = 4;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    PEND   = 2'd1,
    ISSUED = 2'd2,
    DONE   = 2'd3
  } toy_icache_slot_state_e;

endpackage

// File: rtl/toy_icache_resp_slot.sv
// One entry of the icache outstanding-request table.
// Holds the state of a single fetch plus its address, ROB entry id and
// returned data.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   alloc            capture alloc_addr / alloc_entry_id, FREE -> PEND
//   issue            memory request accepted, PEND -> ISSUED
//   rsp, rsp_data    memory response for this slot, ISSUED -> DONE
//   ack_load         slot copied into the ack register, DONE -> FREE
//   state            current slot state
//   addr, entry_id   captured request fields
//   data             captured response data
//
// state  | meaning
// FREE   | unused, may be allocated
// PEND   | request captured, waiting for the memory handshake
// ISSUED | read sent to memory, waiting for the tagged response
// DONE   | data returned, waiting to be loaded into the ack register
module toy_icache_resp_slot
  import toy_pack::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alloc,
  input  logic [ADDR_WIDTH-1:0]         alloc_addr,
  input  logic [ROB_ENTRY_ID_WIDTH-1:0] alloc_entry_id,
  input  logic                          issue,
  input  logic                          rsp,
  input  logic [FETCH_DATA_WIDTH-1:0]   rsp_data,
  input  logic                          ack_load,
  output toy_icache_slot_state_e        state,
  output logic [ADDR_WIDTH-1:0]         addr,
  output logic [ROB_ENTRY_ID_WIDTH-1:0] entry_id,
  output logic [FETCH_DATA_WIDTH-1:0]   data
);

  toy_icache_slot_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FREE;
    end else begin
      state_q <= state_d;
    end
  end

  // Each event is only honoured in the state it belongs to; a response
  // that hits a FREE/PEND/DONE slot is dropped here.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FREE:    if (alloc)    state_d = PEND;
      PEND:    if (issue)    state_d = ISSUED;
      ISSUED:  if (rsp)      state_d = DONE;
      DONE:    if (ack_load) state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      entry_id <= '0;
      data     <= '0;
    end else begin
      if (alloc && state_q == FREE) begin
        addr     <= alloc_addr;
        entry_id <= alloc_entry_id;
      end
      if (rsp && state_q == ISSUED) begin
        data <= rsp_data;
      end
    end
  end

  assign state = state_q;

endmodule

// File: rtl/toy_icache_resp.sv
// Icache fetch-response engine on the BPU/ROB side.
// Tracks fetch requests in an outstanding-slot table, issues line reads to
// memory, accepts out-of-order tagged responses and returns one ack per
// request to the ROB through a single output register.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   fetch_req_*                     fetch request in (vld/rdy, addr, ROB entry id)
//   mem_req_*                       memory read request out (vld/rdy, addr, slot tag)
//   mem_rsp_*                       memory response in (always accepted)
//   icache_ack_*                    ack to ROB (vld/rdy, data, original entry id)
//   idle                            table empty and no ack pending
module toy_icache_resp
  import toy_pack::*;
#(
  parameter  int SLOT_NUM      = ICACHE_SLOT_NUM,
  parameter  int ADDR_WIDTH    = 32,
  localparam int SLOT_ID_WIDTH = $clog2(SLOT_NUM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fetch_req_vld,
  output logic                          fetch_req_rdy,
  input  logic [ADDR_WIDTH-1:0]         fetch_req_addr,
  input  logic [ROB_ENTRY_ID_WIDTH-1:0] fetch_req_entry_id,
  output logic                          mem_req_vld,
  input  logic                          mem_req_rdy,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  output logic [SLOT_ID_WIDTH-1:0]      mem_req_tag,
  input  logic                          mem_rsp_vld,
  input  logic [SLOT_ID_WIDTH-1:0]      mem_rsp_tag,
  input  logic [FETCH_DATA_WIDTH-1:0]   mem_rsp_data,
  output logic                          icache_ack_vld,
  input  logic                          icache_ack_rdy,
  output logic [FETCH_DATA_WIDTH-1:0]   icache_ack_pld,
  output logic [ROB_ENTRY_ID_WIDTH-1:0] icache_ack_entry_id,
  output logic                          idle
);

  toy_icache_slot_state_e        slot_state    [SLOT_NUM];
  logic [ADDR_WIDTH-1:0]         slot_addr     [SLOT_NUM];
  logic [ROB_ENTRY_ID_WIDTH-1:0] slot_entry_id [SLOT_NUM];
  logic [FETCH_DATA_WIDTH-1:0]   slot_data     [SLOT_NUM];

  logic [SLOT_NUM-1:0] free_vec, pend_vec, done_vec;
  logic [SLOT_NUM-1:0] alloc_vec, issue_vec, rsp_vec, ack_load_vec;

  logic [SLOT_ID_WIDTH-1:0] alloc_idx, pend_low_idx, issue_idx;
  logic [SLOT_ID_WIDTH-1:0] grant_idx, rr_cand, rr_ptr_q;
  logic                     grant_vld;
  logic                     hold_q;
  logic [SLOT_ID_WIDTH-1:0] hold_idx_q;
  logic                     fetch_fire, mem_fire, ack_open, ack_load;

  always_comb begin
    free_vec = '0;
    pend_vec = '0;
    done_vec = '0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      free_vec[i] = (slot_state[i] == FREE);
      pend_vec[i] = (slot_state[i] == PEND);
      done_vec[i] = (slot_state[i] == DONE);
    end
  end

  // Lowest-index FREE and PEND slots.
  always_comb begin
    alloc_idx    = '0;
    pend_low_idx = '0;
    for (int i = SLOT_NUM - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx    = SLOT_ID_WIDTH'(i);
      if (pend_vec[i]) pend_low_idx = SLOT_ID_WIDTH'(i);
    end
  end

  assign fetch_req_rdy = |free_vec;
  assign fetch_fire    = fetch_req_vld && fetch_req_rdy;

  // A stalled memory request stays locked to its slot: otherwise a lower
  // slot allocated during the stall would change addr/tag mid-request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      hold_q     <= mem_req_vld && !mem_req_rdy;
      hold_idx_q <= issue_idx;
    end
  end

  assign issue_idx    = hold_q ? hold_idx_q : pend_low_idx;
  assign mem_req_vld  = |pend_vec;
  assign mem_req_addr = slot_addr[issue_idx];
  assign mem_req_tag  = issue_idx;
  assign mem_fire     = mem_req_vld && mem_req_rdy;

  // Round-robin pick among DONE slots, starting at rr_ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr_q;
    rr_cand   = '0;
    for (int k = 0; k < SLOT_NUM; k++) begin
      rr_cand = rr_ptr_q + SLOT_ID_WIDTH'(k);
      if (!grant_vld && done_vec[rr_cand]) begin
        grant_vld = 1'b1;
        grant_idx = rr_cand;
      end
    end
  end

  assign ack_open = !icache_ack_vld || icache_ack_rdy;
  assign ack_load = ack_open && grant_vld;

  always_comb begin
    alloc_vec    = '0;
    issue_vec    = '0;
    rsp_vec      = '0;
    ack_load_vec = '0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      alloc_vec[i]    = fetch_fire  && (alloc_idx   == SLOT_ID_WIDTH'(i));
      issue_vec[i]    = mem_fire    && (issue_idx   == SLOT_ID_WIDTH'(i));
      rsp_vec[i]      = mem_rsp_vld && (mem_rsp_tag == SLOT_ID_WIDTH'(i));
      ack_load_vec[i] = ack_load    && (grant_idx   == SLOT_ID_WIDTH'(i));
    end
  end

  for (genvar g = 0; g < SLOT_NUM; g++) begin : g_slot
    toy_icache_resp_slot #(
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_slot (
      .clk            (clk),
      .rst_n          (rst_n),
      .alloc          (alloc_vec[g]),
      .alloc_addr     (fetch_req_addr),
      .alloc_entry_id (fetch_req_entry_id),
      .issue          (issue_vec[g]),
      .rsp            (rsp_vec[g]),
      .rsp_data       (mem_rsp_data),
      .ack_load       (ack_load_vec[g]),
      .state          (slot_state[g]),
      .addr           (slot_addr[g]),
      .entry_id       (slot_entry_id[g]),
      .data           (slot_data[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icache_ack_vld      <= 1'b0;
      icache_ack_pld      <= '0;
      icache_ack_entry_id <= '0;
      rr_ptr_q            <= '0;
    end else if (ack_load) begin
      icache_ack_vld      <= 1'b1;
      icache_ack_pld      <= slot_data[grant_idx];
      icache_ack_entry_id <= slot_entry_id[grant_idx];
      rr_ptr_q            <= grant_idx + 1'b1;
    end else if (ack_open) begin
      icache_ack_vld      <= 1'b0;
    end
  end

  assign idle = (&free_vec) && !icache_ack_vld;

`ifndef SYNTHESIS
  // Responses to PEND or DONE slots are protocol errors. A FREE slot is
  // tolerated: reads still in flight across a reset come back to FREE slots.
  always_ff @(posedge clk) begin
    if (rst_n && mem_rsp_vld) begin
      assert (slot_state[mem_rsp_tag] == ISSUED || slot_state[mem_rsp_tag] == FREE)
        else $error("toy_icache_resp: response tag %0d hits a non-ISSUED slot", mem_rsp_tag);
    end
  end
`endif

endmodule

// File: tb/tb_toy_icache_resp.sv
module tb_toy_icache_resp;
  import toy_pack::*;

  localparam int AW = 32;
  localparam int TW = 2;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic                          fetch_req_vld = 1'b0;
  logic                          fetch_req_rdy;
  logic [AW-1:0]                 fetch_req_addr = '0;
  logic [ROB_ENTRY_ID_WIDTH-1:0] fetch_req_entry_id = '0;
  logic                          mem_req_vld;
  logic                          mem_req_rdy = 1'b1;
  logic [AW-1:0]                 mem_req_addr;
  logic [TW-1:0]                 mem_req_tag;
  logic                          mem_rsp_vld = 1'b0;
  logic [TW-1:0]                 mem_rsp_tag = '0;
  logic [FETCH_DATA_WIDTH-1:0]   mem_rsp_data = '0;
  logic                          icache_ack_vld;
  logic                          icache_ack_rdy = 1'b1;
  logic [FETCH_DATA_WIDTH-1:0]   icache_ack_pld;
  logic [ROB_ENTRY_ID_WIDTH-1:0] icache_ack_entry_id;
  logic                          idle;

  toy_icache_resp #(.SLOT_NUM(4), .ADDR_WIDTH(AW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fetch_req_vld       (fetch_req_vld),
    .fetch_req_rdy       (fetch_req_rdy),
    .fetch_req_addr      (fetch_req_addr),
    .fetch_req_entry_id  (fetch_req_entry_id),
    .mem_req_vld         (mem_req_vld),
    .mem_req_rdy         (mem_req_rdy),
    .mem_req_addr        (mem_req_addr),
    .mem_req_tag         (mem_req_tag),
    .mem_rsp_vld         (mem_rsp_vld),
    .mem_rsp_tag         (mem_rsp_tag),
    .mem_rsp_data        (mem_rsp_data),
    .icache_ack_vld      (icache_ack_vld),
    .icache_ack_rdy      (icache_ack_rdy),
    .icache_ack_pld      (icache_ack_pld),
    .icache_ack_entry_id (icache_ack_entry_id),
    .idle                (idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROB_ENTRY_ID_WIDTH-1:0] entry;
    logic [FETCH_DATA_WIDTH-1:0]   data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [ROB_ENTRY_ID_WIDTH-1:0] e, input logic [FETCH_DATA_WIDTH-1:0] d);
    exp_t x;
    x.entry = e;
    x.data  = d;
    sb.push_back(x);
  endtask

  // Scoreboard monitor: every ack handshake pops the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t x;
    if (rst_n && icache_ack_vld && icache_ack_rdy) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ack_unexpected actual_entry=%0d actual_pld=0x%0h expected=none",
                 icache_ack_entry_id, icache_ack_pld);
      end else begin
        x = sb.pop_front();
        check("ack_entry", 64'(icache_ack_entry_id), 64'(x.entry));
        check("ack_pld", 64'(icache_ack_pld), 64'(x.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [AW-1:0] a, input logic [ROB_ENTRY_ID_WIDTH-1:0] e);
    int n = 0;
    fetch_req_vld      = 1'b1;
    fetch_req_addr     = a;
    fetch_req_entry_id = e;
    @(negedge clk);
    while (!fetch_req_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!fetch_req_rdy) begin
      checks++;
      failures++;
      $display("FAIL req_timeout actual_rdy=0 expected_rdy=1 entry=%0d", e);
    end
    step();
    fetch_req_vld = 1'b0;
  endtask

  task automatic rsp(input logic [TW-1:0] t, input logic [FETCH_DATA_WIDTH-1:0] d);
    mem_rsp_vld  = 1'b1;
    mem_rsp_tag  = t;
    mem_rsp_data = d;
    step();
    mem_rsp_vld  = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [ROB_ENTRY_ID_WIDTH-1:0] b2b_exp [3];

  initial begin
    // ---- reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ack_vld", 64'(icache_ack_vld), 0);
    check("rst_ack_pld", 64'(icache_ack_pld), 0);
    check("rst_ack_entry", 64'(icache_ack_entry_id), 0);
    check("rst_mem_req_vld", 64'(mem_req_vld), 0);
    check("rst_fetch_rdy", 64'(fetch_req_rdy), 1);
    check("rst_idle", 64'(idle), 1);
    step();

    // ---- single request
    req(32'h100, 4'd3);
    @(negedge clk);
    check("t1_mem_vld", 64'(mem_req_vld), 1);
    check("t1_mem_addr", 64'(mem_req_addr), 64'h100);
    check("t1_mem_tag", 64'(mem_req_tag), 0);
    check("t1_not_idle", 64'(idle), 0);
    step();
    push_exp(4'd3, 32'hA5);
    rsp(2'd0, 32'hA5);
    @(negedge clk);
    check("t1_ack_lat1", 64'(icache_ack_vld), 0);
    step();
    @(negedge clk);
    check("t1_ack_lat2", 64'(icache_ack_vld), 1);
    check("t1_mem_vld_off", 64'(mem_req_vld), 0);
    step();
    @(negedge clk);
    check("t1_idle_back", 64'(idle), 1);
    step();

    // ---- fill table, 5th request held
    for (int i = 0; i < 4; i++) req(32'h200 + 32'(16 * i), 4'(i));
    fetch_req_vld      = 1'b1;
    fetch_req_addr     = 32'h300;
    fetch_req_entry_id = 4'd4;
    push_exp(4'd2, 32'h22);
    mem_rsp_vld  = 1'b1;
    mem_rsp_tag  = 2'd2;
    mem_rsp_data = 32'h22;
    @(negedge clk);
    check("t2_full_rdy", 64'(fetch_req_rdy), 0);
    step();
    mem_rsp_vld = 1'b0;
    @(negedge clk);
    check("t2_held_rdy", 64'(fetch_req_rdy), 0);
    check("t2_ack_wait", 64'(icache_ack_vld), 0);
    step();
    @(negedge clk);
    check("t2_freed_rdy", 64'(fetch_req_rdy), 1);
    check("t2_ack_vld", 64'(icache_ack_vld), 1);
    step();
    fetch_req_vld = 1'b0;
    @(negedge clk);
    check("t2_realloc_vld", 64'(mem_req_vld), 1);
    check("t2_realloc_tag", 64'(mem_req_tag), 2);
    check("t2_realloc_addr", 64'(mem_req_addr), 64'h300);
    step();

    // ---- out-of-order responses 2,0,3,1
    push_exp(4'd4, 32'h1002); rsp(2'd2, 32'h1002); step(); step();
    push_exp(4'd0, 32'h1000); rsp(2'd0, 32'h1000); step(); step();
    push_exp(4'd3, 32'h1003); rsp(2'd3, 32'h1003); step(); step();
    push_exp(4'd1, 32'h1001); rsp(2'd1, 32'h1001);
    repeat (4) step();
    @(negedge clk);
    check("t3_idle", 64'(idle), 1);
    check("t3_drained", 64'(sb.size()), 0);
    step();

    // ---- ack backpressure, round-robin release
    req(32'h400, 4'd5);
    req(32'h410, 4'd6);
    req(32'h420, 4'd7);
    step();
    step();
    icache_ack_rdy = 1'b0;
    push_exp(4'd6, 32'h60);
    rsp(2'd1, 32'h60);
    rsp(2'd0, 32'h50);
    rsp(2'd2, 32'h70);
    push_exp(4'd7, 32'h70);
    push_exp(4'd5, 32'h50);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_stall_vld", 64'(icache_ack_vld), 1);
      check("t4_stall_entry", 64'(icache_ack_entry_id), 6);
      check("t4_stall_pld", 64'(icache_ack_pld), 64'h60);
      step();
    end
    icache_ack_rdy = 1'b1;
    b2b_exp[0] = 4'd6;
    b2b_exp[1] = 4'd7;
    b2b_exp[2] = 4'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_b2b_vld", 64'(icache_ack_vld), 1);
      check("t4_b2b_entry", 64'(icache_ack_entry_id), 64'(b2b_exp[i]));
      step();
    end
    @(negedge clk);
    check("t4_after_vld", 64'(icache_ack_vld), 0);
    step();

    // ---- same-cycle alloc + issue + response + ack-load
    mem_req_rdy = 1'b0;
    req(32'h500, 4'd8);
    req(32'h540, 4'd9);
    req(32'h580, 4'd10);
    mem_req_rdy = 1'b1;
    step();
    step();
    mem_req_rdy = 1'b0;
    push_exp(4'd8, 32'h80);
    rsp(2'd0, 32'h80);
    fetch_req_vld      = 1'b1;
    fetch_req_addr     = 32'h5C0;
    fetch_req_entry_id = 4'd11;
    mem_req_rdy        = 1'b1;
    push_exp(4'd9, 32'h90);
    mem_rsp_vld  = 1'b1;
    mem_rsp_tag  = 2'd1;
    mem_rsp_data = 32'h90;
    @(negedge clk);
    check("t5_pre_tag", 64'(mem_req_tag), 2);
    check("t5_pre_ack", 64'(icache_ack_vld), 0);
    step();
    fetch_req_vld = 1'b0;
    mem_rsp_vld   = 1'b0;
    @(negedge clk);
    check("t5_ack_vld", 64'(icache_ack_vld), 1);
    check("t5_ack_entry", 64'(icache_ack_entry_id), 8);
    check("t5_mem_tag", 64'(mem_req_tag), 3);
    check("t5_mem_addr", 64'(mem_req_addr), 64'h5C0);
    step();
    @(negedge clk);
    check("t5_ack2_entry", 64'(icache_ack_entry_id), 9);
    step();
    push_exp(4'd10, 32'hA0); rsp(2'd2, 32'hA0);
    push_exp(4'd11, 32'hB0); rsp(2'd3, 32'hB0);
    repeat (4) step();
    @(negedge clk);
    check("t5_idle", 64'(idle), 1);
    check("t5_drained", 64'(sb.size()), 0);
    step();

    // ---- async reset with two ISSUED slots, late responses ignored
    req(32'h600, 4'd12);
    req(32'h640, 4'd13);
    step();
    step();
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_mem_vld", 64'(mem_req_vld), 0);
    check("t6_rst_idle", 64'(idle), 1);
    check("t6_rst_rdy", 64'(fetch_req_rdy), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rsp(2'd0, 32'hDEAD);
    rsp(2'd1, 32'hBEEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_ack_vld", 64'(icache_ack_vld), 0);
      check("t6_ack_pld", 64'(icache_ack_pld), 0);
      check("t6_ack_entry", 64'(icache_ack_entry_id), 0);
      check("t6_idle", 64'(idle), 1);
      check("t6_mem_vld", 64'(mem_req_vld), 0);
      step();
    end
    check("final_drained", 64'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
